// File: rtl/nibble_serial_adder_pkg.sv
// Shared FSM encodings and sizing helpers for the nibble-serial adder.
package nibble_serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int unsigned NIBBLE_W = 4;

  // Width of a counter that must reach n-1; a 1-nibble adder still gets one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_adder4bit.sv
// Team 4-bit combinational ripple-carry adder.
module adder4bit (
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic       cin,
  output logic [3:0] out,
  output logic       carry
);

  logic [4:0] cy;

  always_comb begin
    cy    = '0;
    out   = '0;
    cy[0] = cin;
    for (int i = 0; i < 4; i++) begin
      out[i]  = in1[i] ^ in2[i] ^ cy[i];
      cy[i+1] = (in1[i] & in2[i]) | (cy[i] & (in1[i] ^ in2[i]));
    end
    carry = cy[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-nibble adder: one nibble per clock through a single adder4bit, LS nibble first.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned CW   = cnt_width(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_q, c_d;
  logic          cout_q, cout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [3:0]    add_out;
  logic          add_carry;
  logic [W-1:0]  acc_nxt;

  adder4bit u_adder (
    .in1   (a_sh_q[3:0]),
    .in2   (b_sh_q[3:0]),
    .cin   (c_q),
    .out   (add_out),
    .carry (add_carry)
  );

  // New nibble enters acc from the top so nibble 0 lands at bit 0 after NIBBLES steps.
  assign acc_nxt = W'({add_out, acc_q} >> NIBBLE_W);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;

    case (state_q)
      ST_RUN: begin
        a_sh_d = a_sh_q >> NIBBLE_W;
        b_sh_d = b_sh_q >> NIBBLE_W;
        c_d    = add_carry;
        acc_d  = acc_nxt;
        if (cnt_q == LAST) begin
          sum_d   = acc_nxt;
          cout_d  = add_carry;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // IDLE, DONE and the unused encoding all accept a new start.
      default: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at NIBBLES = 4, 1 and 8.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        start4, cin4, busy4, done4, cout4;
  logic [15:0] a4, b4, sum4;
  logic [16:0] q4[$];
  logic [16:0] e4;
  int          done_cnt4 = 0;

  logic        start1, cin1, busy1, done1, cout1;
  logic [3:0]  a1, b1, sum1;
  logic [4:0]  q1[$];
  logic [4:0]  e1;

  logic        start8, cin8, busy8, done8, cout8;
  logic [31:0] a8, b8, sum8;
  logic [32:0] q8[$];
  logic [32:0] e8;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  nibble_serial_adder #(.NIBBLES(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

  // Result monitors: pop the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!reset && busy4 && done4) begin
      checks++; errors++;
      $display("FAIL overlap4: busy=%0b done=%0b required not both high", busy4, done4);
    end
    if (!reset && done4) begin
      done_cnt4++;
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done4: got {cout,sum}=%h required no done", {cout4, sum4});
      end else begin
        e4 = q4.pop_front();
        if ({cout4, sum4} !== e4) begin
          errors++;
          $display("FAIL result4: got {cout,sum}=%h required %h", {cout4, sum4}, e4);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done1: got %h required no done", {cout1, sum1});
      end else begin
        e1 = q1.pop_front();
        if ({cout1, sum1} !== e1) begin
          errors++;
          $display("FAIL result1: got {cout,sum}=%h required %h", {cout1, sum1}, e1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done8: got %h required no done", {cout8, sum8});
      end else begin
        e8 = q8.pop_front();
        if ({cout8, sum8} !== e8) begin
          errors++;
          $display("FAIL result8: got {cout,sum}=%h required %h", {cout8, sum8}, e8);
        end
      end
    end
  end

  // Callers sit just after a rising edge with the DUT idle.
  task automatic start_op4(input logic [15:0] a, input logic [15:0] b, input logic c);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    q4.push_back(17'(a) + 17'(b) + 17'(c));
    @(posedge clk); #1 start4 = 1'b0;
  endtask

  task automatic wait_done4(input string name);
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (done4) break;
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL timeout4_%s: got no done in 40 cycles required done", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic start_op1(input logic [3:0] a, input logic [3:0] b, input logic c);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    q1.push_back(5'(a) + 5'(b) + 5'(c));
    @(posedge clk); #1 start1 = 1'b0;
  endtask

  task automatic wait_done1();
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (done1) break;
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL timeout1: got no done required done");
    end
    @(posedge clk); #1;
  endtask

  task automatic start_op8(input logic [31:0] a, input logic [31:0] b, input logic c);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back(33'(a) + 33'(b) + 33'(c));
    @(posedge clk); #1 start8 = 1'b0;
  endtask

  task automatic wait_done8();
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (done8) break;
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL timeout8: got no done required done");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start4 = 0; a4 = '0; b4 = '0; cin4 = 0;
    start1 = 0; a1 = '0; b1 = '0; cin1 = 0;
    start8 = 0; a8 = '0; b8 = '0; cin8 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy4, done4, cout4, sum4} !== 19'd0) begin
      errors++;
      $display("FAIL reset4: got busy=%0b done=%0b cout=%0b sum=%h required all 0",
               busy4, done4, cout4, sum4);
    end
    checks++;
    if ({busy1, done1, cout1, sum1, busy8, done8, cout8, sum8} !== 43'd0) begin
      errors++;
      $display("FAIL reset_1_8: got sum1=%h sum8=%h required 0", sum1, sum8);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int bc = 0;
    int dc = 0;
    start_op4(16'h1234, 16'h4321, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy4) begin
        bc++;
        checks++;
        if (sum4 !== 16'h0000) begin
          errors++;
          $display("FAIL sum_hidden: got sum=%h while busy required 0000", sum4);
        end
      end
      if (done4) dc++;
    end
    checks++;
    if (bc != 4) begin
      errors++;
      $display("FAIL busy_len: got %0d cycles required 4", bc);
    end
    checks++;
    if (dc != 1) begin
      errors++;
      $display("FAIL done_len: got %0d cycles required 1", dc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_carry();
    start_op4(16'hFFFF, 16'h0001, 1'b0); wait_done4("ripple");
    start_op4(16'hFFFF, 16'h0000, 1'b1); wait_done4("cin");
    start_op4(16'h0000, 16'h0000, 1'b0); wait_done4("zero");
  endtask

  task automatic test_ignore_start();
    int d0;
    d0 = done_cnt4;
    start_op4(16'h0F0F, 16'h0101, 1'b0);
    @(posedge clk); #1;
    a4 = 16'hFFFF; b4 = 16'hFFFF; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    wait_done4("ignore");
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (done_cnt4 - d0 != 1) begin
      errors++;
      $display("FAIL ignore_pulses: got %0d done pulses required 1", done_cnt4 - d0);
    end
  endtask

  task automatic test_reset_mid_run();
    int d0;
    start_op4(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy4, done4, cout4, sum4} !== 19'd0) begin
      errors++;
      $display("FAIL abort: got busy=%0b done=%0b cout=%0b sum=%h required all 0",
               busy4, done4, cout4, sum4);
    end
    q4.delete();
    @(posedge clk); #1 reset = 1'b0;
    d0 = done_cnt4;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (done_cnt4 != d0) begin
      errors++;
      $display("FAIL abort_done: got %0d done pulses required 0", done_cnt4 - d0);
    end
    start_op4(16'h0007, 16'h0009, 1'b0); wait_done4("after_abort");
  endtask

  task automatic test_back_to_back();
    int d0;
    logic [15:0] la, lb;
    logic lc;
    d0 = done_cnt4;
    for (int k = 0; k < 6; k++) begin
      la = 16'($urandom); lb = 16'($urandom); lc = 1'($urandom);
      a4 = la; b4 = lb; cin4 = lc; start4 = 1'b1;
      q4.push_back(17'(la) + 17'(lb) + 17'(lc));
      @(posedge clk);
      repeat (4) begin
        #1 a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
        @(posedge clk);
      end
      #1;
    end
    start4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt4 - d0 != 6 || q4.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: got %0d results, %0d pending required 6 results, 0 pending",
               done_cnt4 - d0, q4.size());
    end
  endtask

  task automatic test_random4();
    for (int i = 0; i < 20; i++) begin
      start_op4(16'($urandom), 16'($urandom), 1'($urandom));
      wait_done4("random");
    end
  endtask

  task automatic test_nibbles1();
    start_op1(4'hF, 4'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL nib1_run: got busy=%0b done=%0b required busy=1 done=0", busy1, done1);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL nib1_done: got busy=%0b done=%0b required busy=0 done=1", busy1, done1);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      start_op1(4'($urandom), 4'($urandom), 1'($urandom));
      wait_done1();
    end
  endtask

  task automatic test_nibbles8();
    start_op8(32'hFFFF_FFFF, 32'h0000_0000, 1'b1); wait_done8();
    start_op8(32'h8765_4321, 32'h1234_5678, 1'b0); wait_done8();
    for (int i = 0; i < 10; i++) begin
      start_op8($urandom, $urandom, 1'($urandom));
      wait_done8();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random4();
    test_nibbles1();
    test_nibbles8();
    checks++;
    if (q4.size() + q1.size() + q8.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d unchecked results required 0",
               q4.size() + q1.size() + q8.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
